// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Summary  : Command FIFO and issue FSM in front of a combinational ALU, with a
//            registered valid/ready result port and an accumulator feedback path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     cmd_cin,
    input  logic [2:0]               cmd_opc,
    input  logic                     cmd_acc,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic                     alu_cin,
    output logic [2:0]               alu_opc,
    input  logic [WIDTH-1:0]         alu_w,
    input  logic                     alu_f0,
    input  logic                     alu_f1,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_w,
    output logic                     res_f0,
    output logic                     res_f1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic             acc;
        logic [2:0]       opc;
        logic             cin;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    cmd_t                 mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic                 alu_cin_q, alu_cin_d;
    logic [2:0]           alu_opc_q, alu_opc_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     res_w_q, res_w_d;
    logic                 res_f0_q, res_f0_d;
    logic                 res_f1_q, res_f1_d;
    logic                 res_valid_q, res_valid_d;

    logic                 push;
    logic                 pop;
    cmd_t                 head;
    cmd_t                 cmd_in;

    // Readiness is a function of registered occupancy only; a pop on the same
    // edge does not open a slot until the following cycle.
    assign cmd_ready = (count_q < c_CNT_W'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign cmd_in    = '{acc: cmd_acc, opc: cmd_opc, cin: cmd_cin, b: cmd_b, a: cmd_a};

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        acc_d       = acc_q;
        res_w_d     = res_w_q;
        res_f0_d    = res_f0_q;
        res_f1_d    = res_f1_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_w_d     = alu_w;
                res_f0_d    = alu_f0;
                res_f1_d    = alu_f1;
                acc_d       = alu_w;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        alu_opc_d = alu_opc_q;
        if (pop) begin
            alu_a_d   = head.acc ? acc_q : head.a;
            alu_b_d   = head.b;
            alu_cin_d = head.cin;
            alu_opc_d = head.opc;
        end
        wr_ptr_d = wr_ptr_q + c_PTR_W'(push);
        rd_ptr_d = rd_ptr_q + c_PTR_W'(pop);
        count_d  = count_q + c_CNT_W'(push) - c_CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_opc_q   <= '0;
            acc_q       <= '0;
            res_w_q     <= '0;
            res_f0_q    <= 1'b0;
            res_f1_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_opc_q   <= alu_opc_d;
            acc_q       <= acc_d;
            res_w_q     <= res_w_d;
            res_f0_q    <= res_f0_d;
            res_f1_q    <= res_f1_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_opc   = alu_opc_q;
    assign res_valid = res_valid_q;
    assign res_w     = res_w_q;
    assign res_f0    = res_f0_q;
    assign res_f1    = res_f1_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
